// File: rtl/c64_mem_ctrl_if.sv
// CPU-side bus of the C64 memory controller, plus the ROM and I/O side-band buses.
// master = the system (CPU core and external chips); slave = c64_mem_ctrl.
interface c64_mem_ctrl_if;
  logic [15:0] ab;
  logic [7:0]  cpu_do;
  logic        we;
  logic [7:0]  cpu_di;
  logic [7:0]  rom_data;
  logic        basic_cs;
  logic        kernal_cs;
  logic        char_cs;
  logic [12:0] rom_addr;
  logic        io_cs;
  logic        io_we;
  logic [11:0] io_addr;
  logic [7:0]  io_dout;
  logic [7:0]  io_din;
  logic [5:0]  port_pins;

  modport master (
    output ab, cpu_do, we, rom_data, io_din,
    input  cpu_di, basic_cs, kernal_cs, char_cs, rom_addr,
           io_cs, io_we, io_addr, io_dout, port_pins
  );

  modport slave (
    input  ab, cpu_do, we, rom_data, io_din,
    output cpu_di, basic_cs, kernal_cs, char_cs, rom_addr,
           io_cs, io_we, io_addr, io_dout, port_pins
  );
endinterface

// File: rtl/c64_mem_ctrl.sv
// C64 memory controller: 64 KiB RAM, 6510 processor port at $0000/$0001 and bank decode.
// Bus protocol: no handshake; every cycle is one access, reads are combinational, writes commit at posedge.
module c64_mem_ctrl #(
  parameter int          RAM_AW   = 16,
  parameter logic [7:0]  DDR_RST  = 8'h2F,
  parameter logic [7:0]  PORT_RST = 8'h37
) (
  input  logic          clk,
  input  logic          reset_n,
  c64_mem_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    SRC_RAM, SRC_BASIC, SRC_KERNAL, SRC_CHAR, SRC_IO, SRC_DDR, SRC_PORT
  } src_e;

  logic [7:0]        ddr;
  logic [7:0]        port;
  logic [7:0]        eff;
  logic              loram, hiram, charen;
  src_e              src;
  logic              ram_we;
  logic [RAM_AW-1:0] ram_idx;
  logic [7:0]        ram [2**RAM_AW];

  // Pins configured as inputs float high through the pull-ups.
  assign eff    = (port & ddr) | ~ddr;
  assign loram  = eff[0];
  assign hiram  = eff[1];
  assign charen = eff[2];

  always_comb begin
    src = SRC_RAM;
    if (bus.ab == 16'h0000) begin
      src = SRC_DDR;
    end else if (bus.ab == 16'h0001) begin
      src = SRC_PORT;
    end else begin
      case (bus.ab[15:12])
        4'hA, 4'hB: if (loram && hiram) src = SRC_BASIC;
        4'hD:       if (loram || hiram) src = charen ? SRC_IO : SRC_CHAR;
        4'hE, 4'hF: if (hiram) src = SRC_KERNAL;
        default:    src = SRC_RAM;
      endcase
    end
  end

  assign ram_idx = bus.ab[RAM_AW-1:0];
  // The port registers sit on top of RAM, so writes there also land in RAM; only I/O hides it.
  assign ram_we  = bus.we && (src != SRC_IO);

  always_ff @(posedge clk) begin
    if (reset_n && ram_we) ram[ram_idx] <= bus.cpu_do;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ddr  <= DDR_RST;
      port <= PORT_RST;
    end else if (bus.we) begin
      if (src == SRC_DDR)  ddr  <= bus.cpu_do;
      if (src == SRC_PORT) port <= bus.cpu_do;
    end
  end

  always_comb begin
    bus.cpu_di = ram[ram_idx];
    if (bus.we) begin
      bus.cpu_di = bus.cpu_do;
    end else begin
      case (src)
        SRC_BASIC, SRC_KERNAL, SRC_CHAR: bus.cpu_di = bus.rom_data;
        SRC_IO:   bus.cpu_di = bus.io_din;
        SRC_DDR:  bus.cpu_di = ddr;
        SRC_PORT: bus.cpu_di = eff;
        default:  bus.cpu_di = ram[ram_idx];
      endcase
    end
  end

  assign bus.basic_cs  = reset_n && !bus.we && (src == SRC_BASIC);
  assign bus.kernal_cs = reset_n && !bus.we && (src == SRC_KERNAL);
  assign bus.char_cs   = reset_n && !bus.we && (src == SRC_CHAR);
  assign bus.io_cs     = reset_n && (src == SRC_IO);
  assign bus.io_we     = reset_n && bus.we && (src == SRC_IO);
  assign bus.rom_addr  = bus.ab[12:0];
  assign bus.io_addr   = bus.ab[11:0];
  assign bus.io_dout   = bus.cpu_do;
  assign bus.port_pins = eff[5:0];

endmodule

// File: tb/tb_c64_mem_ctrl.sv
// Directed bench for c64_mem_ctrl: bank map, port register, I/O window and reset behaviour.
module tb_c64_mem_ctrl;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_fail;

  c64_mem_ctrl_if bus ();

  c64_mem_ctrl #(.RAM_AW(16), .DDR_RST(8'h2F), .PORT_RST(8'h37)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a write from the falling edge; sampling window is open until the rising edge.
  task automatic wr_begin(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.ab = a; bus.cpu_do = d; bus.we = 1'b1;
    #2;
  endtask

  task automatic wr_end();
    @(posedge clk);
    #1 bus.we = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    wr_begin(a, d);
    wr_end();
  endtask

  task automatic rd(input logic [15:0] a);
    @(negedge clk);
    bus.ab = a; bus.we = 1'b0;
    #2;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.ab = 16'hA123; bus.we = 1'b0; bus.cpu_do = 8'h00;
    bus.rom_data = 8'hC3; bus.io_din = 8'h0E;
    #2;
    n_cmp++; if (bus.basic_cs !== 1'b0) begin n_fail++; $display("FAIL rst_basic_low: got %b want 0", bus.basic_cs); end
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    #2;
    n_cmp++; if (bus.basic_cs !== 1'b1) begin n_fail++; $display("FAIL rst_basic_a123: got %b want 1", bus.basic_cs); end
    n_cmp++; if (bus.rom_addr !== 13'h0123) begin n_fail++; $display("FAIL rst_rom_addr: got %h want 0123", bus.rom_addr); end
    rd(16'h0000);
    n_cmp++; if (bus.cpu_di !== 8'h2F) begin n_fail++; $display("FAIL rst_ddr: got %h want 2f", bus.cpu_di); end
    rd(16'h0001);
    n_cmp++; if (bus.cpu_di !== 8'hF7) begin n_fail++; $display("FAIL rst_eff: got %h want f7", bus.cpu_di); end
    n_cmp++; if (bus.port_pins !== 6'h37) begin n_fail++; $display("FAIL rst_pins: got %h want 37", bus.port_pins); end
  endtask

  task automatic test_ram_basic();
    wr(16'h0011, 8'h39);
    rd(16'h0011);
    n_cmp++; if (bus.cpu_di !== 8'h39) begin n_fail++; $display("FAIL ram_0011: got %h want 39", bus.cpu_di); end
    wr_begin(16'hA000, 8'h5A);
    n_cmp++; if (bus.basic_cs !== 1'b0) begin n_fail++; $display("FAIL basic_cs_on_write: got %b want 0", bus.basic_cs); end
    n_cmp++; if (bus.cpu_di !== 8'h5A) begin n_fail++; $display("FAIL di_echo_write: got %h want 5a", bus.cpu_di); end
    wr_end();
    rd(16'hA000);
    n_cmp++; if (bus.basic_cs !== 1'b1) begin n_fail++; $display("FAIL basic_cs_read: got %b want 1", bus.basic_cs); end
    n_cmp++; if (bus.cpu_di !== 8'hC3) begin n_fail++; $display("FAIL basic_data: got %h want c3", bus.cpu_di); end
    // eff = F6: LORAM drops, BASIC banked out.
    wr_begin(16'h0001, 8'h36);
    n_cmp++; if (bus.port_pins !== 6'h37) begin n_fail++; $display("FAIL port_same_cycle: got %h want 37", bus.port_pins); end
    wr_end();
    rd(16'hA000);
    n_cmp++; if (bus.cpu_di !== 8'h5A) begin n_fail++; $display("FAIL ram_under_basic: got %h want 5a", bus.cpu_di); end
    n_cmp++; if (bus.basic_cs !== 1'b0) begin n_fail++; $display("FAIL basic_cs_off: got %b want 0", bus.basic_cs); end
    n_cmp++; if (bus.port_pins !== 6'h36) begin n_fail++; $display("FAIL pins_36: got %h want 36", bus.port_pins); end
  endtask

  task automatic test_io();
    wr(16'h0001, 8'h34);
    wr(16'hD020, 8'hAA);
    wr(16'h0001, 8'h37);
    rd(16'hD020);
    n_cmp++; if (bus.io_cs !== 1'b1) begin n_fail++; $display("FAIL io_cs_read: got %b want 1", bus.io_cs); end
    n_cmp++; if (bus.io_we !== 1'b0) begin n_fail++; $display("FAIL io_we_read: got %b want 0", bus.io_we); end
    n_cmp++; if (bus.cpu_di !== 8'h0E) begin n_fail++; $display("FAIL io_data: got %h want 0e", bus.cpu_di); end
    n_cmp++; if (bus.io_addr !== 12'h020) begin n_fail++; $display("FAIL io_addr: got %h want 020", bus.io_addr); end
    wr_begin(16'hD020, 8'h05);
    n_cmp++; if (bus.io_we !== 1'b1 || bus.io_cs !== 1'b1) begin n_fail++; $display("FAIL io_write_strobe: got cs=%b we=%b want 1 1", bus.io_cs, bus.io_we); end
    n_cmp++; if (bus.io_dout !== 8'h05) begin n_fail++; $display("FAIL io_dout: got %h want 05", bus.io_dout); end
    wr_end();
    wr(16'h0001, 8'h34);
    rd(16'hD020);
    n_cmp++; if (bus.cpu_di !== 8'hAA) begin n_fail++; $display("FAIL ram_under_io: got %h want aa", bus.cpu_di); end
    n_cmp++; if (bus.io_cs !== 1'b0) begin n_fail++; $display("FAIL io_cs_ram_map: got %b want 0", bus.io_cs); end
  endtask

  task automatic test_char_kernal();
    // eff = F3: LORAM=HIRAM=1, CHAREN=0.
    wr(16'h0001, 8'h33);
    rd(16'hD000);
    n_cmp++; if (bus.char_cs !== 1'b1 || bus.io_cs !== 1'b0) begin n_fail++; $display("FAIL char_cs: got char=%b io=%b want 1 0", bus.char_cs, bus.io_cs); end
    n_cmp++; if (bus.cpu_di !== 8'hC3) begin n_fail++; $display("FAIL char_data: got %h want c3", bus.cpu_di); end
    wr_begin(16'hD000, 8'h77);
    n_cmp++; if (bus.char_cs !== 1'b0) begin n_fail++; $display("FAIL char_cs_write: got %b want 0", bus.char_cs); end
    wr_end();
    wr(16'hE000, 8'h11);
    rd(16'hFFFF);
    n_cmp++; if (bus.kernal_cs !== 1'b1) begin n_fail++; $display("FAIL kernal_cs: got %b want 1", bus.kernal_cs); end
    n_cmp++; if (bus.rom_addr !== 13'h1FFF) begin n_fail++; $display("FAIL kernal_addr: got %h want 1fff", bus.rom_addr); end
    // eff = F0: everything is RAM.
    wr(16'h0001, 8'h30);
    rd(16'hA000);
    n_cmp++; if (bus.cpu_di !== 8'h5A || bus.basic_cs !== 1'b0) begin n_fail++; $display("FAIL all_ram_a000: got %h cs=%b want 5a 0", bus.cpu_di, bus.basic_cs); end
    rd(16'hD000);
    n_cmp++; if (bus.cpu_di !== 8'h77 || bus.char_cs !== 1'b0 || bus.io_cs !== 1'b0) begin n_fail++; $display("FAIL all_ram_d000: got %h char=%b io=%b want 77 0 0", bus.cpu_di, bus.char_cs, bus.io_cs); end
    rd(16'hE000);
    n_cmp++; if (bus.cpu_di !== 8'h11 || bus.kernal_cs !== 1'b0) begin n_fail++; $display("FAIL all_ram_e000: got %h cs=%b want 11 0", bus.cpu_di, bus.kernal_cs); end
  endtask

  task automatic test_ddr_zero();
    wr(16'h0000, 8'h00);
    rd(16'h0001);
    n_cmp++; if (bus.cpu_di !== 8'hFF) begin n_fail++; $display("FAIL eff_ddr0: got %h want ff", bus.cpu_di); end
    n_cmp++; if (bus.port_pins !== 6'h3F) begin n_fail++; $display("FAIL pins_ddr0: got %h want 3f", bus.port_pins); end
    rd(16'h0000);
    n_cmp++; if (bus.cpu_di !== 8'h00) begin n_fail++; $display("FAIL ddr_read0: got %h want 00", bus.cpu_di); end
    rd(16'hA000);
    n_cmp++; if (bus.basic_cs !== 1'b1) begin n_fail++; $display("FAIL default_map_basic: got %b want 1", bus.basic_cs); end
    rd(16'hD020);
    n_cmp++; if (bus.io_cs !== 1'b1) begin n_fail++; $display("FAIL default_map_io: got %b want 1", bus.io_cs); end
  endtask

  task automatic test_reset_mid_write();
    @(negedge clk);
    bus.ab = 16'h0001; bus.cpu_do = 8'h30; bus.we = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (bus.port_pins !== 6'h37) begin n_fail++; $display("FAIL async_port_reset: got %h want 37", bus.port_pins); end
    // Default map puts $D020 in I/O; strobes must still stay low during reset.
    bus.ab = 16'hD020;
    #1;
    n_cmp++; if (bus.io_cs !== 1'b0 || bus.io_we !== 1'b0) begin n_fail++; $display("FAIL io_low_in_reset: got cs=%b we=%b want 0 0", bus.io_cs, bus.io_we); end
    bus.ab = 16'h0001;
    @(posedge clk); #1;
    n_cmp++; if (bus.port_pins !== 6'h37) begin n_fail++; $display("FAIL write_suppressed: got %h want 37", bus.port_pins); end
    @(negedge clk);
    bus.we = 1'b0; reset_n = 1'b1;
    #2;
    n_cmp++; if (bus.cpu_di !== 8'hF7) begin n_fail++; $display("FAIL port_after_reset: got %h want f7", bus.cpu_di); end
    rd(16'h0000);
    n_cmp++; if (bus.cpu_di !== 8'h2F) begin n_fail++; $display("FAIL ddr_after_reset: got %h want 2f", bus.cpu_di); end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    test_reset();
    test_ram_basic();
    test_io();
    test_char_kernal();
    test_ddr_zero();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
